var_lat_rd_sequencer: RTL

//  Sequences one write-then-read transaction with a latency chosen per request, the way the

---
 rtl/var_lat_rd_sequencer_pkg.sv | 35 +++
 rtl/var_lat_rd_sequencer_lat_countdown.sv | 29 ++
 rtl/var_lat_rd_sequencer_sva.sv | 78 +++++++
 rtl/var_lat_rd_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/var_lat_rd_sequencer_pkg.sv
// Shared types for the variable-latency read sequencer: FSM state encoding and
// the latency clamp helper used at request accept time.
package var_lat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] lat;
    logic        clamped;
  } clamp_res_t;

  // Unsigned clamp into [min_lat, max_lat]; callers zero-extend LAT_W values to 32 bits.
  function automatic clamp_res_t clamp_lat(input logic [31:0] lat,
                                           input logic [31:0] min_lat,
                                           input logic [31:0] max_lat);
    clamp_res_t res;
    if (lat < min_lat) begin
      res.lat     = min_lat;
      res.clamped = 1'b1;
    end else if (lat > max_lat) begin
      res.lat     = max_lat;
      res.clamped = 1'b1;
    end else begin
      res.lat     = lat;
      res.clamped = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/var_lat_rd_sequencer_lat_countdown.sv
// Loadable down-counter that saturates at zero; used for both the write-phase
// length and the read-latency wait.
module lat_countdown #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {W{1'b0}})) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/var_lat_rd_sequencer_sva.sv
// Protocol checker bound into the sequencer: wr pulse length, wr-fall to
// rsp_valid latency, and response stability under backpressure.
module var_lat_rd_sequencer_sva #(
  parameter int DATA_W    = 32,
  parameter int LAT_W     = 8,
  parameter int WR_CYCLES = 5
) (
  input logic              i_clk,
  input logic              i_rst,
  input logic              i_rsp_ready,
  input logic              o_wr,
  input logic              o_rsp_valid,
  input logic [DATA_W-1:0] o_rsp_data,
  input logic [LAT_W-1:0]  i_eff_lat
);

  int                r_wr_run;
  int                r_wait_cnt;
  logic              r_wr_d;
  logic              r_armed;
  logic              r_hold;
  logic [DATA_W-1:0] r_data_d;

  // Track wr run length and the wait since wr fell, checking each on its closing cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_run   <= 0;
      r_wait_cnt <= 0;
      r_wr_d     <= 1'b0;
      r_armed    <= 1'b0;
      r_hold     <= 1'b0;
      r_data_d   <= {DATA_W{1'b0}};
    end else begin
      r_wr_d   <= o_wr;
      r_hold   <= o_rsp_valid && !i_rsp_ready;
      r_data_d <= o_rsp_data;
      if (o_wr) begin
        r_wr_run <= r_wr_run + 1;
      end else begin
        r_wr_run <= 0;
      end
      if (!o_wr && r_wr_d) begin
        assert (r_wr_run == WR_CYCLES) else $error("wr high for %0d cycles", r_wr_run);
        if (o_rsp_valid) begin
          assert (i_eff_lat == {LAT_W{1'b0}}) else $error("rsp_valid early");
        end else begin
          r_armed    <= 1'b1;
          r_wait_cnt <= 1;
        end
      end else if (r_armed) begin
        if (o_rsp_valid) begin
          assert (r_wait_cnt == 32'(i_eff_lat)) else $error("latency %0d", r_wait_cnt);
          r_armed <= 1'b0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1;
        end
      end
      if (r_hold) begin
        assert (o_rsp_valid && (o_rsp_data == r_data_d)) else $error("rsp not held");
      end
    end
  end

endmodule

bind var_lat_rd_sequencer var_lat_rd_sequencer_sva #(
  .DATA_W    (DATA_W),
  .LAT_W     (LAT_W),
  .WR_CYCLES (WR_CYCLES)
) u_sva (
  .i_clk       (i_clk),
  .i_rst       (i_rst),
  .i_rsp_ready (i_rsp_ready),
  .o_wr        (o_wr),
  .o_rsp_valid (o_rsp_valid),
  .o_rsp_data  (o_rsp_data),
  .i_eff_lat   (r_eff_lat)
);

// File: rtl/var_lat_rd_sequencer.sv
// Write-then-read transaction sequencer: holds wr for WR_CYCLES, waits a clamped
// per-request latency, then presents req_data + OFFSET until accepted.
module var_lat_rd_sequencer
  import var_lat_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int LAT_W     = 8,
  parameter int WR_CYCLES = 5,
  parameter int MIN_LAT   = 10,
  parameter int MAX_LAT   = 20,
  parameter int OFFSET    = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [LAT_W-1:0]  i_req_lat,
  input  logic [DATA_W-1:0] i_req_data,
  output logic              o_wr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_busy,
  output logic              o_lat_clamp
);

  state_e            r_state;
  state_e            w_next_state;
  logic              w_accept;
  clamp_res_t        w_clamp;
  logic [LAT_W-1:0]  r_eff_lat;
  logic [LAT_W-1:0]  w_lat_load_val;
  logic              w_wr_zero;
  logic              w_lat_zero;
  logic              w_wr_load;
  logic              w_wr_dec;
  logic              w_lat_load;
  logic              w_lat_dec;
  logic              w_wr_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_busy_nxt;
  logic              w_lat_clamp_nxt;
  logic              r_wr;
  logic              r_rsp_valid;
  logic              r_busy;
  logic              r_lat_clamp;
  logic [DATA_W-1:0] r_rsp_data;

  assign w_accept = i_req_valid && (r_state == IDLE);
  assign w_clamp  = clamp_lat(32'(i_req_lat), 32'(MIN_LAT), 32'(MAX_LAT));

  // The latency counter is loaded with eff_lat-1 so RESP lands exactly eff_lat cycles after wr falls.
  assign w_lat_load_val = (r_eff_lat == {LAT_W{1'b0}}) ? {LAT_W{1'b0}}
                                                       : r_eff_lat - LAT_W'(1);
  assign w_wr_load  = w_accept;
  assign w_wr_dec   = (r_state == WRITE);
  assign w_lat_load = (r_state == WRITE) && w_wr_zero;
  assign w_lat_dec  = (r_state == WAIT);

  lat_countdown #(.W(LAT_W)) u_wr_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_wr_load),
    .i_load_val (LAT_W'(WR_CYCLES - 1)),
    .i_dec      (w_wr_dec),
    .o_zero     (w_wr_zero)
  );

  lat_countdown #(.W(LAT_W)) u_lat_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (w_lat_load),
    .i_load_val (w_lat_load_val),
    .i_dec      (w_lat_dec),
    .o_zero     (w_lat_zero)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          w_next_state = WRITE;
        end else begin
          w_next_state = IDLE;
        end
      end
      WRITE: begin
        if (w_wr_zero) begin
          w_next_state = (r_eff_lat == {LAT_W{1'b0}}) ? RESP : WAIT;
        end else begin
          w_next_state = WRITE;
        end
      end
      WAIT: begin
        if (w_lat_zero) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // FSM output decode from the next state, so the registered outputs line up with the state
  always_comb begin
    w_wr_nxt        = (w_next_state == WRITE);
    w_rsp_valid_nxt = (w_next_state == RESP);
    w_busy_nxt      = (w_next_state != IDLE);
    w_lat_clamp_nxt = w_accept && w_clamp.clamped;
  end

  // Output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_lat_clamp <= 1'b0;
    end else begin
      r_wr        <= w_wr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_lat_clamp <= w_lat_clamp_nxt;
    end
  end

  // Capture latency and response data at accept; the add wraps modulo 2^DATA_W
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_eff_lat  <= {LAT_W{1'b0}};
      r_rsp_data <= {DATA_W{1'b0}};
    end else if (w_accept) begin
      r_eff_lat  <= LAT_W'(w_clamp.lat);
      r_rsp_data <= i_req_data + DATA_W'(OFFSET);
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_wr        = r_wr;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_busy      = r_busy;
  assign o_lat_clamp = r_lat_clamp;

endmodule
